// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 write-only bus controller:
// FSM state encoding, default timing constants and a width helper.
package hd44780_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_SETUP = 3'd1;
    localparam state_t ST_PULSE = 3'd2;
    localparam state_t ST_HOLD  = 3'd3;
    localparam state_t ST_EXEC  = 3'd4;

    localparam int DEF_TICK_DIV    = 50;
    localparam int DEF_SETUP_TICKS = 1;
    localparam int DEF_PULSE_TICKS = 2;
    localparam int DEF_HOLD_TICKS  = 1;
    localparam int DEF_EXEC_TICKS  = 40;

    function automatic int tmax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hd44780_bus_ctrl_if.sv
// Requester handshake plus HD44780 pin bundle.
// master: requester side; slave: controller side.
interface hd44780_bus_ctrl_if;
    import hd44780_pkg::*;

    logic       req_valid;
    logic       req_rs;
    logic [7:0] req_data;
    logic       req_ready;
    logic       busy;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic [7:0] lcd_db;

    modport master (
        output req_valid, req_rs, req_data,
        input  req_ready, busy, lcd_rs, lcd_rw, lcd_e, lcd_db
    );

    modport slave (
        input  req_valid, req_rs, req_data,
        output req_ready, busy, lcd_rs, lcd_rw, lcd_e, lcd_db
    );

endinterface

// File: rtl/hd44780_tick_gen.sv
// Timing tick source: one-cycle tick every TICK_DIV clocks.
// Ports: clk, rst (async active-low), restart (sync), tick.
module hd44780_tick_gen
    import hd44780_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);

    logic [W-1:0] div_q, div_d;

    assign tick = (div_q == W'(TICK_DIV - 1));

    always_comb begin
        div_d = div_q + W'(1);
        if (tick || restart) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/hd44780_bus_ctrl.sv
// HD44780 write-only bus controller: SETUP/PULSE/HOLD/EXEC strobe.
// Ports: clk, rst (async active-low), bus (slave). HD44780_NIBBLE_EN: 4-bit.
module hd44780_bus_ctrl
    import hd44780_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SETUP_TICKS = DEF_SETUP_TICKS,
    parameter int PULSE_TICKS = DEF_PULSE_TICKS,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
    parameter int EXEC_TICKS  = DEF_EXEC_TICKS
) (
    input  logic                clk,
    input  logic                rst,
    hd44780_bus_ctrl_if.slave   bus
);

    localparam int MAXT = tmax(tmax(SETUP_TICKS, PULSE_TICKS),
                               tmax(HOLD_TICKS, EXEC_TICKS));
    localparam int CW   = $clog2(MAXT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
`ifdef HD44780_NIBBLE_EN
    logic [3:0]    lo_q, lo_d;
    logic          second_q, second_d;
`endif

    logic          tick;
    logic          accept;
    logic          phase_done;
    logic [CW-1:0] last;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // Restart on accept so every phase is tick-aligned to the accept edge.
    hd44780_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .tick    (tick)
    );

    always_comb begin
        last = '0;
        case (state_q)
            ST_SETUP: last = CW'(SETUP_TICKS - 1);
            ST_PULSE: last = CW'(PULSE_TICKS - 1);
            ST_HOLD:  last = CW'(HOLD_TICKS - 1);
            ST_EXEC:  last = CW'(EXEC_TICKS - 1);
            default:  last = '0;
        endcase
    end

    assign phase_done = tick && (cnt_q == last);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        db_d     = db_q;
`ifdef HD44780_NIBBLE_EN
        lo_d     = lo_q;
        second_d = second_q;
`endif
        if (state_q == ST_IDLE) begin
            if (accept) begin
                state_d  = ST_SETUP;
                cnt_d    = '0;
                rs_d     = bus.req_rs;
`ifdef HD44780_NIBBLE_EN
                db_d     = {bus.req_data[7:4], 4'h0};
                lo_d     = bus.req_data[3:0];
                second_d = 1'b0;
`else
                db_d     = bus.req_data;
`endif
            end
        end else if (phase_done) begin
            cnt_d = '0;
            case (state_q)
                ST_SETUP: state_d = ST_PULSE;
                ST_PULSE: state_d = ST_HOLD;
                ST_HOLD: begin
`ifdef HD44780_NIBBLE_EN
                    if (!second_q) begin
                        state_d  = ST_SETUP;
                        second_d = 1'b1;
                        db_d     = {lo_q, 4'h0};
                    end else begin
                        state_d  = ST_EXEC;
                    end
`else
                    state_d = ST_EXEC;
`endif
                end
                ST_EXEC:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end else if (tick) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rs_q     <= 1'b0;
            db_q     <= '0;
`ifdef HD44780_NIBBLE_EN
            lo_q     <= '0;
            second_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
`ifdef HD44780_NIBBLE_EN
            lo_q     <= lo_d;
            second_q <= second_d;
`endif
        end
    end

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.lcd_e     = (state_q == ST_PULSE);
    assign bus.lcd_rs    = rs_q;
    assign bus.lcd_db    = db_q;
    assign bus.lcd_rw    = 1'b0;

endmodule

// File: tb/tb_hd44780_bus_ctrl.sv
// Directed bench for hd44780_bus_ctrl at TICK_DIV=4, 1/2/1/3 ticks.
// Follows HD44780_NIBBLE_EN for expected bus values and latency.
module tb_hd44780_bus_ctrl;

    localparam int TD = 4;
    localparam int ST = 1;
    localparam int PT = 2;
    localparam int HT = 1;
    localparam int ET = 3;
`ifdef HD44780_NIBBLE_EN
    localparam int NIB = 1;
`else
    localparam int NIB = 0;
`endif
    localparam int PPB = NIB ? 2 : 1;
    localparam int LAT = (PPB * (ST + PT + HT) + ET) * TD;
    localparam int EHI = PPB * PT * TD;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic [7:0] db8;
        logic [7:0] dbhi;
        logic [7:0] dblo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hd44780_bus_ctrl_if bus();

    hd44780_bus_ctrl #(
        .TICK_DIV    (TD),
        .SETUP_TICKS (ST),
        .PULSE_TICKS (PT),
        .HOLD_TICKS  (HT),
        .EXEC_TICKS  (ET)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_acc  = 0;
    int n_rise = 0;
    int last_acc = 0;
    int prev_acc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && bus.req_valid && bus.req_ready) begin
            n_acc    <= n_acc + 1;
            prev_acc <= last_acc;
            last_acc <= cyc;
        end
    end

    always @(posedge bus.lcd_e) n_rise <= n_rise + 1;

    vec_t vecs[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ready(input string nm);
        int k;
        k = 0;
        while (!bus.req_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: req_ready timeout, got 0, expected 1", nm);
        end
    endtask

    task automatic xfer(input vec_t v, input string nm);
        int k, pulses, ehi, lat;
        logic [7:0] setup_db, db0, db1, first;
        logic rs0, prev_e;
        wait_ready(nm);
        bus.req_valid = 1'b1;
        bus.req_rs    = v.rs;
        bus.req_data  = v.data;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0; pulses = 0; ehi = 0; lat = -1;
        prev_e = 1'b0; setup_db = '0; db0 = '0; db1 = '0; rs0 = 1'b0;
        while (k < 300) begin
            if (bus.req_ready) begin
                lat = k;
                break;
            end
            if (k == 0) setup_db = bus.lcd_db;
            if (bus.lcd_e && !prev_e) begin
                if (pulses == 0) begin
                    db0 = bus.lcd_db;
                    rs0 = bus.lcd_rs;
                end else begin
                    db1 = bus.lcd_db;
                end
                pulses++;
            end
            if (bus.lcd_e) ehi++;
            prev_e = bus.lcd_e;
            @(negedge clk);
            k++;
        end
        first = NIB ? v.dbhi : v.db8;
        chk({nm, "_setup_db"}, int'(setup_db), int'(first));
        chk({nm, "_pulse_db"}, int'(db0), int'(first));
        if (NIB) chk({nm, "_pulse2_db"}, int'(db1), int'(v.dblo));
        chk({nm, "_rs"}, int'(rs0), int'(v.rs));
        chk({nm, "_pulses"}, pulses, PPB);
        chk({nm, "_e_cycles"}, ehi, EHI);
        chk({nm, "_latency"}, lat, LAT);
        chk({nm, "_rw"}, int'(bus.lcd_rw), 0);
        chk({nm, "_idle_db"}, int'(bus.lcd_db), int'(NIB ? v.dblo : v.db8));
        chk({nm, "_idle_e"}, int'(bus.lcd_e), 0);
    endtask

    initial begin : main
        int a0, r0, k;
        vecs[0] = '{1'b0, 8'h38, 8'h38, 8'h30, 8'h80};
        vecs[1] = '{1'b1, 8'hA5, 8'hA5, 8'hA0, 8'h50};
        vecs[2] = '{1'b1, 8'hFF, 8'hFF, 8'hF0, 8'hF0};
        vecs[3] = '{1'b0, 8'h01, 8'h01, 8'h00, 8'h10};
        vecs[4] = '{1'b1, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 8'hC3, 8'hC3, 8'hC0, 8'h30};

        bus.req_valid = 1'b0;
        bus.req_rs    = 1'b0;
        bus.req_data  = 8'h00;
        rst = 1'b0;
        #1;
        chk("rst_ready", int'(bus.req_ready), 1);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_e", int'(bus.lcd_e), 0);
        chk("rst_db", int'(bus.lcd_db), 0);
        chk("rst_rs", int'(bus.lcd_rs), 0);
        chk("rst_rw", int'(bus.lcd_rw), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            xfer(vecs[i], $sformatf("vec%0d", i));
            repeat (i) @(negedge clk);
        end

        // back-to-back with req_valid held high
        wait_ready("b2b");
        a0 = n_acc; r0 = n_rise;
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b0;
        bus.req_data  = 8'h01;
        k = 0;
        while (n_acc != a0 + 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        bus.req_data = 8'h02;
        k = 0;
        while (n_acc != a0 + 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", n_acc - a0, 2);
        chk("b2b_gap", last_acc - prev_acc, LAT + 1);
        wait_ready("b2b_end");
        chk("b2b_pulses", n_rise - r0, 2 * PPB);
        chk("b2b_db", int'(bus.lcd_db), NIB ? 'h20 : 'h02);

        // request while busy is dropped
        @(negedge clk);
        a0 = n_acc; r0 = n_rise;
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b0;
        bus.req_data  = 8'h11;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (5) @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'h77;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("busy_db", int'(bus.lcd_db), NIB ? 'h10 : 'h11);
        chk("busy_rs", int'(bus.lcd_rs), 0);
        wait_ready("busy_end");
        repeat (2) @(negedge clk);
        chk("busy_accepts", n_acc - a0, 1);
        chk("busy_pulses", n_rise - r0, PPB);
        chk("busy_final_db", int'(bus.lcd_db), NIB ? 'h10 : 'h11);

        // reset during PULSE
        wait_ready("rstp");
        bus.req_valid = 1'b1;
        bus.req_rs    = 1'b1;
        bus.req_data  = 8'hC3;
        @(negedge clk);
        bus.req_valid = 1'b0;
        k = 0;
        while (!bus.lcd_e && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rstp_pre_e", int'(bus.lcd_e), 1);
        chk("rstp_pre_rs", int'(bus.lcd_rs), 1);
        rst = 1'b0;
        #1;
        chk("rstp_e", int'(bus.lcd_e), 0);
        chk("rstp_db", int'(bus.lcd_db), 0);
        chk("rstp_rs", int'(bus.lcd_rs), 0);
        chk("rstp_ready", int'(bus.req_ready), 1);
        chk("rstp_busy", int'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        xfer(vecs[5], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
